// File: rtl/prbs_checker_if.sv
// ---------------------------------------------------------------------------
// prbs_checker_if
// Bundles the receive stream, control and status signals of prbs_checker.
//   control    : 1 = PRBS-7, 0 = PRBS-13
//   clear      : synchronous zeroing of bit_count / err_count
//   rx_valid   : rx_bit carries a received bit this cycle
//   rx_bit     : received serial bit
//   locked     : checker is synchronised to the incoming stream
//   bit_error  : one-cycle pulse for a mismatched bit while locked
//   bit_count  : valid bits checked while locked (saturating)
//   err_count  : errored bits while locked (saturating)
//   dbg_state  : current checker state (0 = HUNT, 1 = LOCKED)
// Stream handshake: a bit is consumed on every rising clock edge where
// rx_valid is 1; there is no back-pressure, the checker always accepts.
// master = stream source / controller, slave = checker.
// ---------------------------------------------------------------------------
interface prbs_checker_if #(
  parameter int CNT_W = 32
);
  logic             control;
  logic             clear;
  logic             rx_valid;
  logic             rx_bit;
  logic             locked;
  logic             bit_error;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;
  logic             dbg_state;

  modport master (
    output control, clear, rx_valid, rx_bit,
    input  locked, bit_error, bit_count, err_count, dbg_state
  );

  modport slave (
    input  control, clear, rx_valid, rx_bit,
    output locked, bit_error, bit_count, err_count, dbg_state
  );
endinterface

// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
// Receive-side PRBS-7 / PRBS-13 checker. Self-synchronises a local reference
// to the received stream (HUNT), then free-runs the reference and counts
// every mismatching bit (LOCKED). Too many errors inside one observation
// window, or a change of pattern mode, drop it back to HUNT.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : prbs_checker_if.slave (stream in, status/counters out)
// ---------------------------------------------------------------------------
module prbs_checker #(
  parameter int CNT_W       = 32,
  parameter int LOCK_COUNT  = 16,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic           clock,
  input  logic           reset,
  prbs_checker_if.slave  bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [12:0]      sr_q,        sr_d;
  logic [3:0]       fill_q,      fill_d;
  logic [MW-1:0]    match_q,     match_d;
  logic [WW-1:0]    win_cnt_q,   win_cnt_d;
  logic [EW-1:0]    win_err_q,   win_err_d;
  logic             ctrl_q,      ctrl_d;
  logic             bit_error_q, bit_error_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             p;
  logic             mismatch;
  logic             mode_change;
  logic [3:0]       n_len;
  logic [MW-1:0]    match_inc;
  logic [WW-1:0]    win_cnt_inc;
  logic [EW-1:0]    win_err_inc;
  logic [CNT_W-1:0] bit_count_inc;
  logic [CNT_W-1:0] err_count_inc;

  always_comb begin
    // Predicted next bit from the history; sr_q[0] is the newest bit.
    p             = bus.control ? (sr_q[6] ^ sr_q[5])
                                : (sr_q[12] ^ sr_q[11] ^ sr_q[10] ^ sr_q[7]);
    mismatch      = p ^ bus.rx_bit;
    mode_change   = bus.control ^ ctrl_q;
    n_len         = bus.control ? 4'd7 : 4'd13;
    match_inc     = match_q + MW'(1);
    win_cnt_inc   = win_cnt_q + WW'(1);
    win_err_inc   = mismatch ? (win_err_q + EW'(1)) : win_err_q;
    bit_count_inc = (bit_count_q == '1) ? bit_count_q : (bit_count_q + CNT_W'(1));
    err_count_inc = (err_count_q == '1) ? err_count_q : (err_count_q + CNT_W'(1));

    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    ctrl_d      = bus.control;
    bit_error_d = 1'b0;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;

    if (mode_change) begin
      // A new pattern invalidates the reference; any bit this cycle is dropped.
      state_d   = HUNT;
      sr_d      = '0;
      fill_d    = '0;
      match_d   = '0;
      win_cnt_d = '0;
      win_err_d = '0;
    end else if (bus.rx_valid) begin
      case (state_q)
        HUNT: begin
          sr_d = {sr_q[11:0], bus.rx_bit};
          if (fill_q < n_len) begin
            fill_d = fill_q + 4'd1;
          end else if (!mismatch && (sr_q != '0)) begin
            // An all-zero history predicts zeros forever, so it never counts.
            match_d = match_inc;
            if (match_inc == MW'(LOCK_COUNT)) begin
              state_d   = LOCKED;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Reference free-runs on its own prediction, not on the input.
          sr_d        = {sr_q[11:0], p};
          bit_count_d = bit_count_inc;
          if (mismatch) begin
            err_count_d = err_count_inc;
            bit_error_d = 1'b1;
          end
          win_cnt_d = win_cnt_inc;
          win_err_d = win_err_inc;
          if (win_err_inc >= EW'(LOSS_THRESH)) begin
            state_d   = HUNT;
            sr_d      = '0;
            fill_d    = '0;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_inc == WW'(WIN_LEN)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end
        end
        default: ;
      endcase
    end

    // Clear wins over any increment in the same cycle.
    if (bus.clear) begin
      bit_count_d = '0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      ctrl_q      <= 1'b0;
      bit_error_q <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      ctrl_q      <= ctrl_d;
      bit_error_q <= bit_error_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.bit_error = bit_error_q;
  assign bus.bit_count = bit_count_q;
  assign bus.err_count = err_count_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
// Bench for prbs_checker. Two instances share the same stimulus: a 32-bit
// counter build and a 4-bit counter build for saturation. A queue-based
// reference model tracks the expected lock state and counters bit by bit.
// ---------------------------------------------------------------------------
module tb_prbs_checker;

  localparam int LOCK_COUNT  = 16;
  localparam int WIN_LEN     = 64;
  localparam int LOSS_THRESH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  prbs_checker_if #(.CNT_W(32)) if1 ();
  prbs_checker_if #(.CNT_W(4))  if2 ();

  assign if2.control  = if1.control;
  assign if2.clear    = if1.clear;
  assign if2.rx_valid = if1.rx_valid;
  assign if2.rx_bit   = if1.rx_bit;

  prbs_checker #(.CNT_W(32), .LOCK_COUNT(LOCK_COUNT), .WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH))
    dut (.clock(clock), .reset(reset), .bus(if1));

  prbs_checker #(.CNT_W(4), .LOCK_COUNT(LOCK_COUNT), .WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH))
    dut_sat (.clock(clock), .reset(reset), .bus(if2));

  int checks   = 0;
  int failures = 0;

  // ---------------- clock/reset ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stream generator ----------------
  // History of transmitted pattern bits, newest at index 0.
  bit g_hist[$];
  bit cur_mode = 1'b1;

  task automatic gen_seed(input logic [12:0] seed);
    g_hist = {};
    for (int i = 0; i < 13; i++) g_hist.push_back(seed[i]);
  endtask

  // Next bit of x^7+x^6+1 or x^13+x^12+x^11+x^8+1 as a recurrence on history.
  task automatic gen_next(output bit b);
    if (cur_mode) b = g_hist[6] ^ g_hist[5];
    else          b = g_hist[12] ^ g_hist[11] ^ g_hist[10] ^ g_hist[7];
    g_hist.push_front(b);
    void'(g_hist.pop_back());
  endtask

  // ---------------- reference model ----------------
  bit     m_hist[$];
  bit     m_locked, m_bit_error, m_ctrl_q;
  int     m_fill, m_match, m_win_cnt, m_win_err;
  longint m_bit_count, m_err_count;

  task automatic m_clear_hist();
    m_hist = {};
    for (int i = 0; i < 13; i++) m_hist.push_back(1'b0);
  endtask

  task automatic m_reset();
    m_clear_hist();
    m_locked = 0; m_bit_error = 0; m_ctrl_q = 0;
    m_fill = 0; m_match = 0; m_win_cnt = 0; m_win_err = 0;
    m_bit_count = 0; m_err_count = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c, input bit clr);
    bit p, nz;
    int n;
    m_bit_error = 0;
    if (c != m_ctrl_q) begin
      m_locked = 0; m_clear_hist();
      m_fill = 0; m_match = 0; m_win_cnt = 0; m_win_err = 0;
    end else if (v) begin
      n  = c ? 7 : 13;
      p  = c ? (m_hist[6] ^ m_hist[5]) : (m_hist[12] ^ m_hist[11] ^ m_hist[10] ^ m_hist[7]);
      nz = 0;
      foreach (m_hist[i]) if (m_hist[i]) nz = 1;
      if (!m_locked) begin
        m_hist.push_front(b); void'(m_hist.pop_back());
        if (m_fill < n) m_fill++;
        else if (p == b && nz) begin
          m_match++;
          if (m_match == LOCK_COUNT) begin m_locked = 1; m_win_cnt = 0; m_win_err = 0; end
        end else m_match = 0;
      end else begin
        m_hist.push_front(p); void'(m_hist.pop_back());
        if (m_bit_count < 64'hFFFF_FFFF) m_bit_count++;
        if (p != b) begin
          if (m_err_count < 64'hFFFF_FFFF) m_err_count++;
          m_bit_error = 1;
          m_win_err++;
        end
        m_win_cnt++;
        if (m_win_err >= LOSS_THRESH) begin
          m_locked = 0; m_clear_hist();
          m_fill = 0; m_match = 0; m_win_cnt = 0; m_win_err = 0;
        end else if (m_win_cnt == WIN_LEN) begin
          m_win_cnt = 0; m_win_err = 0;
        end
      end
    end
    m_ctrl_q = c;
    if (clr) begin m_bit_count = 0; m_err_count = 0; end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit b, input bit c, input bit clr);
    if1.rx_valid = v; if1.rx_bit = b; if1.control = c; if1.clear = clr;
    model_step(v, b, c, clr);
    @(posedge clock); #1;
  endtask

  task automatic send_prbs(input bit flip);
    bit b;
    gen_next(b);
    drive(1'b1, b ^ flip, cur_mode, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, cur_mode, 1'b0);
  endtask

  // Two control toggles guarantee a HUNT start with empty history, then clear.
  task automatic force_hunt(input bit mode);
    drive(1'b0, 1'b0, ~mode, 1'b0);
    drive(1'b0, 1'b0, mode, 1'b0);
    cur_mode = mode;
    drive(1'b0, 1'b0, mode, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (if1.locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", if1.locked); end
    checks++; if (if1.bit_error !== 1'b0) begin failures++; $display("FAIL reset_bit_error: got %b expected 0", if1.bit_error); end
    checks++; if (if1.bit_count !== 32'd0) begin failures++; $display("FAIL reset_bit_count: got %0d expected 0", if1.bit_count); end
    checks++; if (if1.err_count !== 32'd0) begin failures++; $display("FAIL reset_err_count: got %0d expected 0", if1.err_count); end
    checks++; if (if2.bit_count !== 4'd0) begin failures++; $display("FAIL reset_sat_bit_count: got %0d expected 0", if2.bit_count); end
    checks++; if (if1.dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state: got %b expected 0", if1.dbg_state); end
  endtask

  task automatic test_prbs7_lock();
    int err_pulses = 0;
    force_hunt(1'b1);
    gen_seed(13'h7F);
    for (int i = 1; i <= 23; i++) begin
      send_prbs(1'b0);
      if (i == 22) begin checks++; if (if1.locked !== 1'b0) begin failures++; $display("FAIL p7_early_lock: got %b expected 0 at bit 22", if1.locked); end end
      if (i == 23) begin checks++; if (if1.locked !== 1'b1) begin failures++; $display("FAIL p7_lock_bit23: got %b expected 1", if1.locked); end end
    end
    for (int i = 0; i < 100; i++) begin
      send_prbs(1'b0);
      if (if1.bit_error !== 1'b0) err_pulses++;
    end
    checks++; if (err_pulses != 0) begin failures++; $display("FAIL p7_no_error_pulse: got %0d pulses expected 0", err_pulses); end
    checks++; if (if1.bit_count !== 32'd100) begin failures++; $display("FAIL p7_bit_count: got %0d expected 100", if1.bit_count); end
    checks++; if (if1.err_count !== 32'd0) begin failures++; $display("FAIL p7_err_count: got %0d expected 0", if1.err_count); end
  endtask

  task automatic test_single_error_prbs13();
    int pulses = 0;
    force_hunt(1'b0);
    gen_seed(13'($urandom_range(1, 8191)));
    for (int i = 1; i <= 29; i++) begin
      send_prbs(1'b0);
      if (i == 28) begin checks++; if (if1.locked !== 1'b0) begin failures++; $display("FAIL p13_early_lock: got %b expected 0 at bit 28", if1.locked); end end
      if (i == 29) begin checks++; if (if1.locked !== 1'b1) begin failures++; $display("FAIL p13_lock_bit29: got %b expected 1", if1.locked); end end
    end
    for (int i = 0; i < 20; i++) send_prbs(1'b0);
    send_prbs(1'b1);
    checks++; if (if1.bit_error !== 1'b1) begin failures++; $display("FAIL p13_error_pulse: got %b expected 1", if1.bit_error); end
    checks++; if (if1.err_count !== 32'd1) begin failures++; $display("FAIL p13_err_count: got %0d expected 1", if1.err_count); end
    send_prbs(1'b0);
    checks++; if (if1.bit_error !== 1'b0) begin failures++; $display("FAIL p13_pulse_width: got %b expected 0", if1.bit_error); end
    for (int i = 0; i < 50; i++) begin
      send_prbs(1'b0);
      if (if1.bit_error !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL p13_free_run: got %0d later pulses expected 0", pulses); end
    checks++; if (if1.err_count !== 32'd1) begin failures++; $display("FAIL p13_err_final: got %0d expected 1", if1.err_count); end
    checks++; if (if1.bit_count !== 32'd72) begin failures++; $display("FAIL p13_bit_count: got %0d expected 72", if1.bit_count); end
    checks++; if (if1.locked !== 1'b1) begin failures++; $display("FAIL p13_stay_locked: got %b expected 1", if1.locked); end
  endtask

  task automatic test_burst_loss();
    force_hunt(1'b1);
    gen_seed(13'($urandom_range(1, 127)));
    for (int i = 0; i < 23; i++) send_prbs(1'b0);
    checks++; if (if1.locked !== 1'b1) begin failures++; $display("FAIL burst_initial_lock: got %b expected 1", if1.locked); end
    for (int i = 0; i < 10; i++) send_prbs(1'b0);
    for (int e = 1; e <= 8; e++) begin
      send_prbs(1'b1);
      if (e == 7) begin checks++; if (if1.locked !== 1'b1) begin failures++; $display("FAIL burst_7th_error: got locked=%b expected 1", if1.locked); end end
      if (e == 8) begin checks++; if (if1.locked !== 1'b0) begin failures++; $display("FAIL burst_8th_error: got locked=%b expected 0", if1.locked); end end
      if (e < 8) send_prbs(1'b0);
    end
    checks++; if (if1.err_count !== 32'd8) begin failures++; $display("FAIL burst_err_count: got %0d expected 8", if1.err_count); end
    checks++; if (if1.bit_count !== 32'd25) begin failures++; $display("FAIL burst_bit_count: got %0d expected 25", if1.bit_count); end
    for (int i = 1; i <= 23; i++) begin
      send_prbs(1'b0);
      if (i == 22) begin checks++; if (if1.locked !== 1'b0) begin failures++; $display("FAIL relock_early: got %b expected 0", if1.locked); end end
      if (i == 23) begin checks++; if (if1.locked !== 1'b1) begin failures++; $display("FAIL relock_bit23: got %b expected 1", if1.locked); end end
    end
  endtask

  task automatic test_all_zero();
    int lock_seen = 0;
    force_hunt(1'b1);
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b0, cur_mode, 1'b0);
      if (if1.locked !== 1'b0) lock_seen++;
    end
    checks++; if (lock_seen != 0) begin failures++; $display("FAIL zero_never_locks: got %0d locked cycles expected 0", lock_seen); end
  endtask

  task automatic test_mode_toggle_clear();
    logic [31:0] saved;
    bit b;
    force_hunt(1'b1);
    gen_seed(13'($urandom_range(1, 127)));
    for (int i = 0; i < 23; i++) send_prbs(1'b0);
    checks++; if (if1.locked !== 1'b1) begin failures++; $display("FAIL toggle_pre_lock: got %b expected 1", if1.locked); end
    saved = if1.bit_count;
    cur_mode = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (if1.locked !== 1'b0) begin failures++; $display("FAIL toggle_unlock: got %b expected 0", if1.locked); end
    checks++; if (if1.bit_count !== saved) begin failures++; $display("FAIL toggle_bit_ignored: got %0d expected %0d", if1.bit_count, saved); end
    gen_seed(13'($urandom_range(1, 8191)));
    for (int i = 0; i < 29; i++) send_prbs(1'b0);
    checks++; if (if1.locked !== 1'b1) begin failures++; $display("FAIL toggle_relock13: got %b expected 1", if1.locked); end
    gen_next(b);
    drive(1'b1, ~b, 1'b0, 1'b1);
    checks++; if (if1.bit_error !== 1'b1) begin failures++; $display("FAIL clear_error_pulse: got %b expected 1", if1.bit_error); end
    checks++; if (if1.err_count !== 32'd0) begin failures++; $display("FAIL clear_err_count: got %0d expected 0", if1.err_count); end
    checks++; if (if1.bit_count !== 32'd0) begin failures++; $display("FAIL clear_bit_count: got %0d expected 0", if1.bit_count); end
    send_prbs(1'b0);
    checks++; if (if1.bit_count !== 32'd1) begin failures++; $display("FAIL clear_then_count: got %0d expected 1", if1.bit_count); end
  endtask

  task automatic test_random();
    int burst = 0;
    bit b, v, e, clr;
    force_hunt(1'($urandom_range(0, 1)));
    gen_seed(13'($urandom_range(1, 8191)));
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if ($urandom_range(0, 499) == 0) begin
        cur_mode = ~cur_mode;
        gen_seed(13'($urandom_range(1, 8191)));
      end
      if (burst == 0 && $urandom_range(0, 299) == 0) burst = 12;
      v   = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 199) == 0);
      e   = (burst > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      if (v) begin
        gen_next(b);
        if (burst > 0) burst--;
        drive(1'b1, b ^ e, cur_mode, clr);
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), cur_mode, clr);
      end
      checks++; if (if1.locked !== m_locked) begin failures++; $display("FAIL rand_locked cyc %0d: got %b expected %b", cyc, if1.locked, m_locked); end
      checks++; if (if1.bit_error !== m_bit_error) begin failures++; $display("FAIL rand_bit_error cyc %0d: got %b expected %b", cyc, if1.bit_error, m_bit_error); end
      checks++; if (if1.bit_count !== m_bit_count[31:0]) begin failures++; $display("FAIL rand_bit_count cyc %0d: got %0d expected %0d", cyc, if1.bit_count, m_bit_count); end
      checks++; if (if1.err_count !== m_err_count[31:0]) begin failures++; $display("FAIL rand_err_count cyc %0d: got %0d expected %0d", cyc, if1.err_count, m_err_count); end
    end
  endtask

  task automatic test_saturation_reset();
    force_hunt(1'b1);
    gen_seed(13'($urandom_range(1, 127)));
    for (int i = 0; i < 23; i++) send_prbs(1'b0);
    for (int i = 0; i < 20; i++) send_prbs(1'b0);
    send_prbs(1'b1);
    checks++; if (if2.bit_count !== 4'd15) begin failures++; $display("FAIL sat_bit_count: got %0d expected 15", if2.bit_count); end
    checks++; if (if2.err_count !== 4'd1) begin failures++; $display("FAIL sat_err_count: got %0d expected 1", if2.err_count); end
    checks++; if (if1.bit_count !== 32'd21) begin failures++; $display("FAIL wide_bit_count: got %0d expected 21", if1.bit_count); end
    checks++; if (if1.bit_error !== 1'b1) begin failures++; $display("FAIL pre_reset_pulse: got %b expected 1", if1.bit_error); end
    if1.rx_valid = 1'b0; if1.clear = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (if1.locked !== 1'b0 || if2.locked !== 1'b0) begin failures++; $display("FAIL async_reset_locked: got %b/%b expected 0/0", if1.locked, if2.locked); end
    checks++; if (if1.bit_error !== 1'b0) begin failures++; $display("FAIL async_reset_bit_error: got %b expected 0", if1.bit_error); end
    checks++; if (if1.bit_count !== 32'd0 || if1.err_count !== 32'd0) begin failures++; $display("FAIL async_reset_counts: got %0d/%0d expected 0/0", if1.bit_count, if1.err_count); end
    checks++; if (if2.bit_count !== 4'd0 || if2.err_count !== 4'd0) begin failures++; $display("FAIL async_reset_sat_counts: got %0d/%0d expected 0/0", if2.bit_count, if2.err_count); end
    #20 reset = 1'b1;
    m_reset();
    @(posedge clock); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    if1.control = 1'b1; if1.clear = 1'b0; if1.rx_valid = 1'b0; if1.rx_bit = 1'b0;
    m_reset();
    #23 reset = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_prbs7_lock();
    test_single_error_prbs13();
    test_burst_loss();
    test_all_zero();
    test_mode_toggle_clear();
    test_random();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
